// File: rtl/pulser_ublank_seq.sv
// Record-synchronous blanking pulser.
// A rising edge on enable latches the timing configuration and runs a
// sequence of records; in every record each unmasked channel is blanked
// for `high` cycles starting `pulse_gap` cycles into the record.
//
// state | meaning
// IDLE  | waiting for a legal start edge, outputs deasserted
// RUN   | records in progress, u_blank follows the record counter
module pulser_ublank_seq #(
  parameter int CNT_W       = 16,
  parameter int N_CH        = 4,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] record_len,
  input  logic [CNT_W-1:0] pulse_gap,
  input  logic [CNT_W-1:0] high,
  input  logic [7:0]       n_records,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [N_CH-1:0]  u_blank,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [7:0]       rec_cnt
);

  localparam logic [N_CH-1:0] BLANK_OFF = {N_CH{~ACTIVE_HIGH}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic             enable_q;
  // Cleared by reset while enable is high, so a held enable cannot start
  // a sequence until it has been seen low.
  logic             armed_q;
  // High for the cycle between the start edge and the first record edge.
  logic             first_q;
  logic [CNT_W-1:0] len_q, gap_q, high_q, k_q;
  logic [7:0]       nrec_q;
  logic [N_CH-1:0]  mask_q;
  logic [N_CH-1:0]  u_blank_q;
  logic             busy_q, done_q, cfg_err_q;
  logic [7:0]       rec_cnt_q;

  logic             start_edge, stop_edge, in_window, boundary, last_rec;
  logic [CNT_W:0]   win_end;
  logic [N_CH-1:0]  blank_d;
  logic [CNT_W-1:0] k_d;
  logic [7:0]       rec_d;

  // Next-state terms: edge detection, pulse window, record wrap and count.
  always_comb begin
    start_edge = enable & ~enable_q & armed_q;
    stop_edge  = ~enable & enable_q;
    // Window end is one bit wider so gap+high never wraps back into range.
    win_end    = {1'b0, gap_q} + {1'b0, high_q};
    in_window  = (k_q >= gap_q) && ({1'b0, k_q} < win_end);
    blank_d    = (mask_q & {N_CH{in_window}}) ^ BLANK_OFF;
    k_d        = (k_q == len_q - 1'b1) ? '0 : k_q + 1'b1;
    boundary   = ~first_q && (k_q == '0);
    rec_d      = (rec_cnt_q == 8'hFF) ? rec_cnt_q : rec_cnt_q + 8'd1;
    last_rec   = boundary && (nrec_q != 8'd0) && (rec_d == nrec_q);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      armed_q   <= ~enable;
      first_q   <= 1'b1;
      k_q       <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      high_q    <= '0;
      nrec_q    <= '0;
      mask_q    <= '0;
      u_blank_q <= BLANK_OFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      rec_cnt_q <= '0;
    end else begin
      enable_q <= enable;
      armed_q  <= armed_q | ~enable;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          u_blank_q <= BLANK_OFF;
          if (start_edge) begin
            if (record_len == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              len_q     <= record_len;
              gap_q     <= pulse_gap;
              high_q    <= high;
              nrec_q    <= n_records;
              mask_q    <= ch_mask;
              cfg_err_q <= 1'b0;
              busy_q    <= 1'b1;
              rec_cnt_q <= '0;
              k_q       <= '0;
              first_q   <= 1'b1;
              state_q   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (stop_edge) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            u_blank_q <= BLANK_OFF;
          end else if (last_rec) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            u_blank_q <= BLANK_OFF;
            rec_cnt_q <= rec_d;
          end else begin
            u_blank_q <= blank_d;
            k_q       <= k_d;
            first_q   <= 1'b0;
            if (boundary) rec_cnt_q <= rec_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign u_blank = u_blank_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign rec_cnt = rec_cnt_q;

endmodule

// File: doc/pulser_ublank_seq.md
PULSER_UBLANK_SEQ -- requirements
Module: pulser_ublank_seq

Interface
REQ-001 Parameter CNT_W, default 16, width of record_len, pulse_gap, high and the internal cycle counter.
REQ-002 Parameter N_CH, default 4, number of blanking output channels.
REQ-003 Parameter ACTIVE_HIGH, default 1, output polarity; 1 drives asserted blank as 1, 0 drives asserted blank as 0.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  level run request; rising edge starts a sequence, falling edge aborts it.
REQ-007 record_len  input  CNT_W  record period in clk cycles.
REQ-008 pulse_gap  input  CNT_W  cycles from record start to blank assertion.
REQ-009 high  input  CNT_W  blank assertion length in cycles.
REQ-010 n_records  input  8  records per sequence; 0 = continuous.
REQ-011 ch_mask  input  N_CH  per-channel enable; masked channels stay deasserted.
REQ-012 u_blank  output  N_CH  registered blanking outputs.
REQ-013 busy  output  1  high while a sequence runs.
REQ-014 done  output  1  one-cycle pulse at normal sequence completion.
REQ-015 cfg_err  output  1  sticky illegal-configuration flag.
REQ-016 rec_cnt  output  8  records completed in the current or last sequence.

Function
REQ-017 States IDLE, RUN; enable is registered once to detect edges; start edge E is the clk edge sampling enable=1 with previous sample 0.
REQ-018 record_len, pulse_gap, high, n_records and ch_mask are latched at edge E; later input changes do not affect the running sequence.
REQ-019 IDLE->RUN at edge E when latched record_len != 0; busy rises at edge E and rec_cnt clears to 0.
REQ-020 record_len == 0 at edge E: stay IDLE, set cfg_err, outputs stay deasserted; cfg_err clears only at the next legal start edge or on rst.
REQ-021 Record r begins at edge E+1+r*record_len; cycle counter k runs 0..record_len-1 and wraps to 0 at each record boundary.
REQ-022 Channel i asserted during record cycle k iff ch_mask[i]=1 and pulse_gap <= k < pulse_gap+high, comparison in CNT_W+1 bits; no overflow wrap.
REQ-023 u_blank rises on edge E+1+r*record_len+pulse_gap and falls high cycles later: one cycle of latency from start edge, zero extra latency per record.
REQ-024 pulse_gap+high > record_len: pulse truncated at record end, re-asserts per REQ-022 in the next record; high == 0 or pulse_gap >= record_len: no assertion, timing otherwise unchanged.
REQ-025 rec_cnt increments at each record boundary, saturating at 255 in continuous mode.
REQ-026 n_records != 0: at edge E+1+n_records*record_len, RUN->IDLE, busy falls, done pulses high one cycle, u_blank deasserted.
REQ-027 n_records == 0: RUN continues until enable falls.
REQ-028 Enable falling edge in RUN: RUN->IDLE on that edge, u_blank deasserted and busy low on the same edge, done not pulsed, rec_cnt holds.
REQ-029 Falling and rising enable edges cannot coincide; a new rising edge while IDLE restarts from record 0.
REQ-030 Deasserted level on u_blank is ~ACTIVE_HIGH replicated per channel.

Reset
REQ-031 rst sampled high: state IDLE, u_blank deasserted level, busy=0, done=0, cfg_err=0, rec_cnt=0, enable history cleared, counter 0.
REQ-032 rst overrides all activity including mid-record; enable held high through rst release does not start a sequence until it falls and rises again.

Verification
REQ-033 record_len=100, pulse_gap=50, high=10, n_records=3, ch_mask=all-ones, enable rises -> u_blank high at edges E+51..E+60, E+151..E+160, E+251..E+260; done pulse at edge E+301; rec_cnt=3.
REQ-034 record_len=20, pulse_gap=15, high=10, n_records=2 -> u_blank high 5 cycles per record, truncated at record end; done at edge E+41.
REQ-035 n_records=0, record_len=10, pulse_gap=0, high=3, enable dropped at E+47 -> pulses at E+1, E+11, ..., E+41 (3 cycles each), outputs low from E+47, no done, rec_cnt=4.
REQ-036 record_len=0 on rising enable -> cfg_err=1, busy=0, u_blank idle; next start with record_len=8 clears cfg_err and runs.
REQ-037 ch_mask=4'b0101, ACTIVE_HIGH=0 build, record_len=10, pulse_gap=2, high=2 -> channels 0,2 drop low at E+3..E+4, channels 1,3 stay high.
REQ-038 rst asserted mid-pulse at E+55 with enable held high -> all outputs reset next edge; no restart until enable toggles.
